// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Instruction-fetch stage feeding the IF/ID pipeline register. It owns the
// program counter and keeps at most one read outstanding to a
// variable-latency instruction memory. Each returned word is held in a
// one-entry fetch buffer. Hazard stalls are honoured, and redirects from
// later stages steer the fetch stream.
//
// Optional feature: define IFU_PERF_COUNT_EN to build a 32-bit counter of
// instructions consumed by IF/ID. Without the macro, FetchCount is tied to 0.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemValid,
  input  logic [31:0] MemRdata,
  output logic [31:0] PCAddOut,
  output logic [31:0] InstructionOut,
  output logic [31:0] DisplayOut,
  output logic        FetchValid,
  output logic [31:0] FetchCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] fetch_addr;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;
  logic [31:0] buf_pc_add;
  logic        buf_valid;
  logic        mem_req;

  // Redirect targets are always word aligned, so the low two bits are masked off.
  logic [31:0] target;
  logic [31:0] fetch_addr_plus4;

  assign target           = RedirectTarget & 32'hFFFF_FFFC;
  assign fetch_addr_plus4 = fetch_addr + 32'd4;

  // Fetch FSM: PC, the outstanding request address and the fetch buffer.
  // Buffer fields are zeroed whenever the buffer is emptied, so IF/ID sees a NOP bubble.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
      buf_instr  <= 32'd0;
      buf_pc     <= 32'd0;
      buf_pc_add <= 32'd0;
      buf_valid  <= 1'b0;
      mem_req    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state   <= REQ;
          mem_req <= 1'b1;
          if (Redirect) begin
            pc         <= target;
            fetch_addr <= target;
          end else begin
            fetch_addr <= pc;
          end
        end

        REQ: begin
          if (Redirect) begin
            pc <= target;
            if (MemValid) begin
              fetch_addr <= target;
            end else begin
              state <= DRAIN;
            end
          end else if (MemValid) begin
            buf_instr  <= MemRdata;
            buf_pc     <= fetch_addr;
            buf_pc_add <= fetch_addr_plus4;
            buf_valid  <= 1'b1;
            pc         <= fetch_addr_plus4;
            mem_req    <= 1'b0;
            state      <= FULL;
          end
        end

        DRAIN: begin
          if (Redirect) begin
            pc <= target;
          end
          if (MemValid) begin
            fetch_addr <= Redirect ? target : pc;
            state      <= REQ;
          end
        end

        FULL: begin
          if (Redirect || !Stall) begin
            buf_instr  <= 32'd0;
            buf_pc     <= 32'd0;
            buf_pc_add <= 32'd0;
            buf_valid  <= 1'b0;
            mem_req    <= 1'b1;
            state      <= REQ;
            if (Redirect) begin
              pc         <= target;
              fetch_addr <= target;
            end else begin
              fetch_addr <= pc;
            end
          end
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign MemReq         = mem_req;
  assign MemAddr        = fetch_addr;
  assign FetchValid     = buf_valid;
  assign InstructionOut = buf_instr;
  assign DisplayOut     = buf_pc;
  assign PCAddOut       = buf_pc_add;

`ifdef IFU_PERF_COUNT_EN
  logic [31:0] fetch_count;
  logic        consume;

  assign consume = (state == FULL) && !Stall && !Redirect;

  // Consumed-instruction counter: one tick per edge where IF/ID takes the buffered word.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fetch_count <= 32'd0;
    end else if (consume) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  assign FetchCount = fetch_count;
`else
  assign FetchCount = 32'd0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit
// Directed bench for instruction_fetch_unit. A memory responder with a
// fixed latency answers requests. Stimulus pushes the expected fetch PCs
// and directed checks into queues. A monitor process pops these queues and
// compares them against DUT outputs.
// Define IFU_PERF_COUNT_EN to check the consumed-instruction counter.
module tb_instruction_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemValid;
  logic [31:0] MemRdata;
  logic [31:0] PCAddOut;
  logic [31:0] InstructionOut;
  logic [31:0] DisplayOut;
  logic        FetchValid;
  logic [31:0] FetchCount;

  typedef struct {
    string       name;
    logic [31:0] actual;
    logic [31:0] expected;
  } check_t;

  logic [31:0] expPcQ[$];
  check_t      checkQ[$];
  int          assertCount = 0;
  int          failCount = 0;
  int          memLatency = 2;
  bit          strayReq = 1'b0;

`ifdef IFU_PERF_COUNT_EN
  localparam logic [31:0] EXP_COUNT = 32'd10;
`else
  localparam logic [31:0] EXP_COUNT = 32'd0;
`endif

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .Stall(Stall),
    .Redirect(Redirect),
    .RedirectTarget(RedirectTarget),
    .MemReq(MemReq),
    .MemAddr(MemAddr),
    .MemValid(MemValid),
    .MemRdata(MemRdata),
    .PCAddOut(PCAddOut),
    .InstructionOut(InstructionOut),
    .DisplayOut(DisplayOut),
    .FetchValid(FetchValid),
    .FetchCount(FetchCount)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return addr ^ 32'hA5C3_0F11;
  endfunction

  task automatic applyStimulus(input logic stall, input logic redirect, input logic [31:0] tgt);
    Stall          = stall;
    Redirect       = redirect;
    RedirectTarget = tgt;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_t c;
    c.name     = name;
    c.actual   = actual;
    c.expected = expected;
    checkQ.push_back(c);
  endtask

  task automatic compareOne(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic waitValidAt(input logic [31:0] pcv, input string tag);
    int n;
    n = 0;
    @(negedge Clk);
    while (!(FetchValid && DisplayOut == pcv) && n < 300) begin
      @(negedge Clk);
      n++;
    end
    if (!(FetchValid && DisplayOut == pcv)) checkOutput({"timeout ", tag}, 32'd0, 32'd1);
  endtask

  task automatic waitMemValidAt(input logic [31:0] addr, input string tag);
    int n;
    n = 0;
    @(negedge Clk);
    while (!(MemValid && MemReq && MemAddr == addr) && n < 300) begin
      @(negedge Clk);
      n++;
    end
    if (!(MemValid && MemReq && MemAddr == addr)) checkOutput({"timeout ", tag}, 32'd0, 32'd1);
  endtask

  // Memory responder: answers in the (memLatency+1)-th cycle of a request
  initial begin
    int cnt;
    cnt      = 0;
    MemValid = 1'b0;
    MemRdata = 32'd0;
    forever begin
      @(posedge Clk);
      #1;
      if (strayReq) begin
        MemValid = 1'b1;
        MemRdata = 32'hDEAD_BEEF;
        strayReq = 1'b0;
        cnt      = 0;
      end else if (!Rst_n) begin
        MemValid = 1'b0;
        cnt      = 0;
      end else if (MemValid) begin
        MemValid = 1'b0;
        cnt      = MemReq ? 1 : 0;
      end else if (MemReq) begin
        cnt++;
        if (cnt > memLatency) begin
          MemValid = 1'b1;
          MemRdata = memWord(MemAddr);
        end
      end
    end
  end

  // Monitor: drains directed checks and scores each newly buffered instruction
  initial begin
    logic        prevValid;
    logic [31:0] pcv;
    check_t      c;
    prevValid = 1'b0;
    forever begin
      @(negedge Clk);
      while (checkQ.size() > 0) begin
        c = checkQ.pop_front();
        compareOne(c.name, c.actual, c.expected);
      end
      if (FetchValid && !prevValid) begin
        if (expPcQ.size() == 0) begin
          compareOne("unexpected fetch DisplayOut", DisplayOut, 32'hFFFF_FFFF);
        end else begin
          pcv = expPcQ.pop_front();
          compareOne("DisplayOut", DisplayOut, pcv);
          compareOne("InstructionOut", InstructionOut, memWord(pcv));
          compareOne("PCAddOut", PCAddOut, pcv + 32'd4);
        end
      end else if (!FetchValid) begin
        compareOne("empty InstructionOut", InstructionOut, 32'd0);
        compareOne("empty DisplayOut", DisplayOut, 32'd0);
        compareOne("empty PCAddOut", PCAddOut, 32'd0);
      end
      prevValid = FetchValid;
    end
  end

  // Watchdog so the run can never hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus
  initial begin
    Rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'd0);

    // Reset values
    @(negedge Clk);
    checkOutput("reset MemReq", {31'd0, MemReq}, 32'd0);
    checkOutput("reset FetchValid", {31'd0, FetchValid}, 32'd0);
    checkOutput("reset FetchCount", FetchCount, 32'd0);

    // Sequential fetch 0,4,8 then stall while holding 8
    expPcQ.push_back(32'h0);
    expPcQ.push_back(32'h4);
    expPcQ.push_back(32'h8);
    Rst_n = 1'b1;
    waitValidAt(32'h8, "fetch pc 8");
    applyStimulus(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      checkOutput("stall FetchValid", {31'd0, FetchValid}, 32'd1);
      checkOutput("stall MemReq", {31'd0, MemReq}, 32'd0);
      checkOutput("stall DisplayOut", DisplayOut, 32'h8);
      checkOutput("stall InstructionOut", InstructionOut, memWord(32'h8));
      checkOutput("stall PCAddOut", PCAddOut, 32'hC);
    end
    applyStimulus(1'b0, 1'b0, 32'd0);

    // Consumption raises MemReq for 12; redirect to 0x40 before the response
    @(negedge Clk);
    checkOutput("post-stall MemReq", {31'd0, MemReq}, 32'd1);
    checkOutput("post-stall MemAddr", MemAddr, 32'hC);
    expPcQ.push_back(32'h40);
    applyStimulus(1'b0, 1'b1, 32'h40);
    @(negedge Clk);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("drain MemReq", {31'd0, MemReq}, 32'd1);
    checkOutput("drain MemAddr", MemAddr, 32'hC);
    checkOutput("drain FetchValid", {31'd0, FetchValid}, 32'd0);
    @(negedge Clk);
    checkOutput("drain MemAddr stable", MemAddr, 32'hC);
    @(negedge Clk);
    checkOutput("redirect MemAddr 0x40", MemAddr, 32'h40);
    checkOutput("redirect MemReq", {31'd0, MemReq}, 32'd1);

    // Redirect to 0x83 in the same cycle as the response for 0x44
    expPcQ.push_back(32'h80);
    waitMemValidAt(32'h44, "response for 0x44");
    applyStimulus(1'b0, 1'b1, 32'h83);
    @(negedge Clk);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("coincident redirect MemAddr", MemAddr, 32'h80);
    checkOutput("coincident redirect MemReq", {31'd0, MemReq}, 32'd1);
    checkOutput("coincident redirect FetchValid", {31'd0, FetchValid}, 32'd0);

    // Enter DRAIN, then assert reset there
    waitValidAt(32'h80, "fetch pc 0x80");
    @(negedge Clk);
    checkOutput("consume MemReq", {31'd0, MemReq}, 32'd1);
    checkOutput("consume MemAddr", MemAddr, 32'h84);
    applyStimulus(1'b0, 1'b1, 32'h100);
    @(negedge Clk);
    applyStimulus(1'b0, 1'b0, 32'd0);
    Rst_n = 1'b0;
    #1;
    checkOutput("async reset MemReq", {31'd0, MemReq}, 32'd0);
    checkOutput("async reset FetchValid", {31'd0, FetchValid}, 32'd0);
    checkOutput("async reset InstructionOut", InstructionOut, 32'd0);
    checkOutput("async reset DisplayOut", DisplayOut, 32'd0);
    checkOutput("async reset PCAddOut", PCAddOut, 32'd0);
    checkOutput("async reset FetchCount", FetchCount, 32'd0);

    // Stray response while IDLE right after reset release is ignored
    @(negedge Clk);
    strayReq = 1'b1;
    expPcQ.push_back(32'h0);
    @(posedge Clk);
    #2;
    Rst_n = 1'b1;
    @(negedge Clk);
    checkOutput("idle stray FetchValid", {31'd0, FetchValid}, 32'd0);
    checkOutput("idle MemReq", {31'd0, MemReq}, 32'd0);
    @(negedge Clk);
    checkOutput("after stray FetchValid", {31'd0, FetchValid}, 32'd0);
    checkOutput("after stray MemReq", {31'd0, MemReq}, 32'd1);
    checkOutput("after stray MemAddr", MemAddr, 32'h0);

    // Ten consumed instructions, then a redirect flushes the buffered 0x28
    for (int i = 1; i <= 10; i++) expPcQ.push_back(32'(i * 4));
    expPcQ.push_back(32'h200);
    waitValidAt(32'h28, "fetch pc 0x28");
    applyStimulus(1'b0, 1'b1, 32'h200);
    @(negedge Clk);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("flush FetchValid", {31'd0, FetchValid}, 32'd0);
    checkOutput("flush MemAddr", MemAddr, 32'h200);
    waitValidAt(32'h200, "fetch pc 0x200");
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("FetchCount after flush", FetchCount, EXP_COUNT);

    repeat (3) @(negedge Clk);
    checkOutput("final hold DisplayOut", DisplayOut, 32'h200);
    checkOutput("final FetchCount", FetchCount, EXP_COUNT);
    checkOutput("scoreboard drained", 32'(expPcQ.size()), 32'd0);
    repeat (2) @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
